// File: rtl/ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// Holds the ALUSel codes, default widths and the ID/EX control bundle.
package ex_operand_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [3:0] ALUSel_ADD  = 4'd0;
    localparam logic [3:0] ALUSel_SUB  = 4'd1;
    localparam logic [3:0] ALUSel_SLL  = 4'd2;
    localparam logic [3:0] ALUSel_SLT  = 4'd3;
    localparam logic [3:0] ALUSel_SLTU = 4'd4;
    localparam logic [3:0] ALUSel_XOR  = 4'd5;
    localparam logic [3:0] ALUSel_SRL  = 4'd6;
    localparam logic [3:0] ALUSel_SRA  = 4'd7;
    localparam logic [3:0] ALUSel_OR   = 4'd8;
    localparam logic [3:0] ALUSel_AND  = 4'd9;
    localparam logic [3:0] ALUSel_BSEL = 4'd10;

    typedef struct packed {
        logic       reg_wen;
        logic       mem_read;
        logic       mem_write;
        logic       asel;
        logic       bsel;
        logic [3:0] alu_sel;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_RESET = '{
        reg_wen:   1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        asel:      1'b0,
        bsel:      1'b0,
        alu_sel:   ALUSel_ADD
    };

    // A bubble keeps the operand selects but drops every side effect.
    function automatic id_ex_ctrl_t bubble_ctrl(input id_ex_ctrl_t c);
        id_ex_ctrl_t b;
        b           = c;
        b.reg_wen   = 1'b0;
        b.mem_read  = 1'b0;
        b.mem_write = 1'b0;
        b.alu_sel   = ALUSel_ADD;
        return b;
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Bypass select for one EX source operand: EX/MEM, then MEM/WB, else regfile.
// Ports: rs_addr, mem/wb producer tuples (rd, wen, data), rf_data in; fwd_data out.
module fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic               mem_wen,
    input  logic [XLEN-1:0]    mem_data,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic               wb_wen,
    input  logic [XLEN-1:0]    wb_data,
    input  logic [XLEN-1:0]    rf_data,
    output logic [XLEN-1:0]    fwd_data
);

    logic rs_nz;
    logic mem_hit;
    logic wb_hit;

    assign rs_nz   = (rs_addr != '0);
    assign mem_hit = mem_wen && (mem_rd_addr == rs_addr) && rs_nz;
    // Younger producer wins, so the WB hit is masked by a MEM hit.
    assign wb_hit  = !mem_hit && wb_wen && (wb_rd_addr == rs_addr) && rs_nz;

    always_comb begin
        fwd_data = rf_data;
        unique case (1'b1)
            mem_hit: fwd_data = mem_data;
            wb_hit:  fwd_data = wb_data;
            default: fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand select, bypassing and load-use stall.
// Ports: ID fields in, EX/MEM and MEM/WB producers in, stall_id and EX fields out.
// Build option EX_FORWARD_EN: enables bypassing; without it any RAW stalls.
module ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_asel,
    input  logic               id_bsel,
    input  logic [3:0]         id_alu_sel,
    input  logic               id_reg_wen,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               ex_flush,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic               mem_reg_wen,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic               wb_reg_wen,
    input  logic [XLEN-1:0]    wb_data,
    output logic               stall_id,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_wen,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [3:0]         ex_alu_sel,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [XLEN-1:0]    ex_store_data
);

    import ex_operand_stage_pkg::*;

    id_ex_ctrl_t        id_ctrl;
    id_ex_ctrl_t        ex_ctrl;
    logic [RADDR_W-1:0] ex_rs1_addr;
    logic [RADDR_W-1:0] ex_rs2_addr;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;
    logic               id_reads_ex;
    logic               haz;
    logic               mem_fwd_en;
    logic               wb_fwd_en;

    assign id_ctrl = '{
        reg_wen:   id_reg_wen,
        mem_read:  id_mem_read,
        mem_write: id_mem_write,
        asel:      id_asel,
        bsel:      id_bsel,
        alu_sel:   id_alu_sel
    };

    assign id_reads_ex =
        (id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
        (id_rs2_used && (id_rs2_addr == ex_rd_addr));

`ifdef EX_FORWARD_EN
    // Only a load in EX cannot be bypassed in time.
    assign haz = ex_valid && ex_ctrl.mem_read &&
                 (ex_rd_addr != '0) && id_reads_ex;

    assign mem_fwd_en = mem_reg_wen;
    assign wb_fwd_en  = wb_reg_wen;
`else
    logic id_reads_mem;
    logic unused_wb_wen;

    assign id_reads_mem =
        (id_rs1_used && (id_rs1_addr == mem_rd_addr)) ||
        (id_rs2_used && (id_rs2_addr == mem_rd_addr));

    // No bypass: wait until the producer reaches WB,
    // where the write-first regfile makes it visible.
    assign haz =
        (ex_valid && ex_ctrl.reg_wen &&
         (ex_rd_addr != '0) && id_reads_ex) ||
        (mem_reg_wen && (mem_rd_addr != '0) && id_reads_mem);

    // Producer enables tied low: muxes collapse to regfile data.
    assign mem_fwd_en    = 1'b0;
    assign wb_fwd_en     = 1'b0;
    assign unused_wb_wen = wb_reg_wen;
`endif

    assign stall_id = haz && id_valid && !ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_RESET;
            ex_pc       <= '0;
            ex_rd_addr  <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
        end else if (ex_flush || stall_id) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= bubble_ctrl(ex_ctrl);
        end else begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_ctrl;
            ex_pc       <= id_pc;
            ex_rd_addr  <= id_rd_addr;
            ex_rs1_addr <= id_rs1_addr;
            ex_rs2_addr <= id_rs2_addr;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
        end
    end

    fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs1 (
        .rs_addr     (ex_rs1_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_wen     (mem_fwd_en),
        .mem_data    (mem_fwd_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_wen      (wb_fwd_en),
        .wb_data     (wb_data),
        .rf_data     (ex_rs1_data),
        .fwd_data    (fwd_rs1)
    );

    fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs2 (
        .rs_addr     (ex_rs2_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_wen     (mem_fwd_en),
        .mem_data    (mem_fwd_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_wen      (wb_fwd_en),
        .wb_data     (wb_data),
        .rf_data     (ex_rs2_data),
        .fwd_data    (fwd_rs2)
    );

    assign ex_reg_wen    = ex_ctrl.reg_wen;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_sel    = ex_ctrl.alu_sel;
    assign ex_op1        = ex_ctrl.asel ? ex_pc : fwd_rs1;
    assign ex_op2        = ex_ctrl.bsel ? ex_imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus stall/flush/reset sequences.
// Expectations follow EX_FORWARD_EN when the bench is built with it.
module tb_ex_operand_stage;

    import ex_operand_stage_pkg::*;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [4:0]  id_rs1_addr = '0;
    logic [4:0]  id_rs2_addr = '0;
    logic [4:0]  id_rd_addr = '0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic [31:0] id_rs1_data = '0;
    logic [31:0] id_rs2_data = '0;
    logic [31:0] id_imm = '0;
    logic        id_asel = 1'b0;
    logic        id_bsel = 1'b0;
    logic [3:0]  id_alu_sel = '0;
    logic        id_reg_wen = 1'b0;
    logic        id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0;
    logic        ex_flush = 1'b0;
    logic [4:0]  mem_rd_addr = '0;
    logic        mem_reg_wen = 1'b0;
    logic [31:0] mem_fwd_data = '0;
    logic [4:0]  wb_rd_addr = '0;
    logic        wb_reg_wen = 1'b0;
    logic [31:0] wb_data = '0;
    logic        stall_id;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_wen;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [3:0]  ex_alu_sel;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_store_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_asel       (id_asel),
        .id_bsel       (id_bsel),
        .id_alu_sel    (id_alu_sel),
        .id_reg_wen    (id_reg_wen),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .ex_flush      (ex_flush),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_wen   (mem_reg_wen),
        .mem_fwd_data  (mem_fwd_data),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_wen    (wb_reg_wen),
        .wb_data       (wb_data),
        .stall_id      (stall_id),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_wen    (ex_reg_wen),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_alu_sel    (ex_alu_sel),
        .ex_op1        (ex_op1),
        .ex_op2        (ex_op2),
        .ex_store_data (ex_store_data)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] d1, d2, imm, pc;
        logic        asel, bsel;
        logic [3:0]  alu;
        logic        rw, mr, mw;
        logic [4:0]  mrd;
        logic        mwen;
        logic [31:0] mdat;
        logic [4:0]  wrd;
        logic        wwen;
        logic [31:0] wdat;
        logic [31:0] e1, e2, est;
    } vec_t;

    vec_t vecs[6];
    vec_t lw;
    vec_t dep;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_id(input vec_t v);
        id_valid     = v.valid;
        id_rs1_addr  = v.rs1;
        id_rs2_addr  = v.rs2;
        id_rd_addr   = v.rd;
        id_rs1_used  = v.u1;
        id_rs2_used  = v.u2;
        id_rs1_data  = v.d1;
        id_rs2_data  = v.d2;
        id_imm       = v.imm;
        id_pc        = v.pc;
        id_asel      = v.asel;
        id_bsel      = v.bsel;
        id_alu_sel   = v.alu;
        id_reg_wen   = v.rw;
        id_mem_read  = v.mr;
        id_mem_write = v.mw;
    endtask

    task automatic drive_prod(input vec_t v);
        mem_rd_addr  = v.mrd;
        mem_reg_wen  = v.mwen;
        mem_fwd_data = v.mdat;
        wb_rd_addr   = v.wrd;
        wb_reg_wen   = v.wwen;
        wb_data      = v.wdat;
    endtask

    task automatic clear_prod();
        mem_reg_wen = 1'b0;
        wb_reg_wen  = 1'b0;
    endtask

    initial begin
        // valid rs1 rs2 rd u1 u2 d1 d2 imm pc asel bsel alu rw mr mw
        // mrd mwen mdat wrd wwen wdat e1 e2 est
        vecs[0] = '{1, 2, 0, 1, 1, 0, 32'd10, 32'd0, 32'd5, 32'h100,
                    0, 1, ALUSel_ADD, 1, 0, 0,
                    0, 0, 32'h0, 0, 0, 32'h0,
                    32'd10, 32'd5, 32'd0};
        vecs[1] = '{1, 3, 4, 6, 1, 1, 32'h11, 32'h22, 32'h0, 32'h104,
                    0, 0, ALUSel_SUB, 1, 0, 0,
                    3, 1, 32'hAAAA, 3, 1, 32'hBBBB,
                    FWD ? 32'hAAAA : 32'h11, 32'h22, 32'h22};
        vecs[2] = '{1, 0, 7, 8, 1, 1, 32'h0, 32'h77, 32'h0, 32'h108,
                    0, 0, ALUSel_XOR, 1, 0, 0,
                    0, 1, 32'h1234, 7, 1, 32'hBBBB,
                    32'h0, FWD ? 32'hBBBB : 32'h77,
                    FWD ? 32'hBBBB : 32'h77};
        vecs[3] = '{1, 10, 9, 0, 1, 1, 32'h3, 32'h99, 32'hFFFFF000,
                    32'h2000, 1, 1, ALUSel_ADD, 0, 0, 1,
                    9, 1, 32'hCAFE, 0, 0, 32'h0,
                    32'h2000, 32'hFFFFF000,
                    FWD ? 32'hCAFE : 32'h99};
        vecs[4] = '{0, 11, 12, 13, 1, 1, 32'd5, 32'd6, 32'h0, 32'h10C,
                    0, 0, ALUSel_OR, 1, 0, 0,
                    0, 0, 32'h0, 12, 0, 32'hDEAD,
                    32'd5, 32'd6, 32'd6};
        vecs[5] = '{1, 14, 15, 16, 1, 1, 32'd1, 32'd2, 32'h0, 32'h110,
                    0, 0, ALUSel_AND, 1, 0, 0,
                    15, 0, 32'h5555, 14, 1, 32'h4444,
                    FWD ? 32'h4444 : 32'd1, 32'd2, 32'd2};
        lw  = '{1, 2, 0, 5, 1, 0, 32'h100, 32'h0, 32'd4, 32'h200,
                0, 1, ALUSel_ADD, 1, 1, 0,
                0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        dep = '{1, 5, 7, 6, 1, 1, 32'h0, 32'd3, 32'h0, 32'h204,
                0, 0, ALUSel_ADD, 1, 0, 0,
                0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};

        // reset state
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", ex_valid, 1'b0);
        check("rst_rwen", ex_reg_wen, 1'b0);
        check("rst_mrd", ex_mem_read, 1'b0);
        check("rst_mwr", ex_mem_write, 1'b0);
        check("rst_alu", ex_alu_sel, ALUSel_ADD);
        check("rst_stall", stall_id, 1'b0);
        check("rst_pc", ex_pc, 32'h0);
        check("rst_op1", ex_op1, 32'h0);
        check("rst_rd", ex_rd_addr, 5'd0);
        rst_n = 1'b1;

        // table vectors
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            drive_id(vecs[i]);
            clear_prod();
            #1;
            check($sformatf("v%0d_stall", i), stall_id, 1'b0);
            @(posedge clk);
            #1;
            drive_prod(vecs[i]);
            #1;
            check($sformatf("v%0d_valid", i), ex_valid, vecs[i].valid);
            check($sformatf("v%0d_rwen", i), ex_reg_wen, vecs[i].rw);
            check($sformatf("v%0d_mwr", i), ex_mem_write, vecs[i].mw);
            check($sformatf("v%0d_alu", i), ex_alu_sel, vecs[i].alu);
            check($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
            check($sformatf("v%0d_rd", i), ex_rd_addr, vecs[i].rd);
            check($sformatf("v%0d_op1", i), ex_op1, vecs[i].e1);
            check($sformatf("v%0d_op2", i), ex_op2, vecs[i].e2);
            check($sformatf("v%0d_st", i), ex_store_data, vecs[i].est);
        end

        // load-use: LW x5 then a consumer of x5
        @(posedge clk);
        #1;
        drive_id(lw);
        clear_prod();
        #1;
        check("lu_pre_stall", stall_id, 1'b0);
        @(posedge clk);
        #1;
        drive_id(dep);
        #1;
        check("lu_ld_in_ex", ex_mem_read, 1'b1);
        check("lu_stall", stall_id, 1'b1);
        @(posedge clk);
        #1;
        check("lu_bub_valid", ex_valid, 1'b0);
        check("lu_bub_rwen", ex_reg_wen, 1'b0);
        check("lu_bub_mrd", ex_mem_read, 1'b0);
        check("lu_bub_alu", ex_alu_sel, ALUSel_ADD);
        mem_rd_addr  = 5'd5;
        mem_reg_wen  = 1'b1;
        mem_fwd_data = 32'h5A5A;
        #1;
`ifdef EX_FORWARD_EN
        check("lu_release", stall_id, 1'b0);
        @(posedge clk);
        #1;
        mem_reg_wen = 1'b0;
        wb_rd_addr  = 5'd5;
        wb_reg_wen  = 1'b1;
        wb_data     = 32'h5A5A;
        #1;
`else
        check("lu_mem_stall", stall_id, 1'b1);
        @(posedge clk);
        #1;
        check("lu_bub2_valid", ex_valid, 1'b0);
        mem_reg_wen = 1'b0;
        wb_rd_addr  = 5'd5;
        wb_reg_wen  = 1'b1;
        wb_data     = 32'h5A5A;
        id_rs1_data = 32'h5A5A;
        #1;
        check("lu_release", stall_id, 1'b0);
        @(posedge clk);
        #1;
`endif
        check("lu_issue_valid", ex_valid, 1'b1);
        check("lu_issue_pc", ex_pc, 32'h204);
        check("lu_issue_op1", ex_op1, 32'h5A5A);
        check("lu_issue_op2", ex_op2, 32'd3);
        clear_prod();

        // flush wins over a load-use hazard
        drive_id(lw);
        @(posedge clk);
        #1;
        drive_id(dep);
        ex_flush = 1'b1;
        #1;
        check("fl_stall", stall_id, 1'b0);
        @(posedge clk);
        #1;
        ex_flush = 1'b0;
        check("fl_valid", ex_valid, 1'b0);
        check("fl_rwen", ex_reg_wen, 1'b0);
        check("fl_mrd", ex_mem_read, 1'b0);

        // async reset between edges while stalled
        drive_id(lw);
        @(posedge clk);
        #1;
        drive_id(dep);
        #1;
        check("ar_pre_stall", stall_id, 1'b1);
        check("ar_pre_valid", ex_valid, 1'b1);
        check("ar_pre_op1", ex_op1, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", ex_valid, 1'b0);
        check("ar_alu", ex_alu_sel, ALUSel_ADD);
        check("ar_stall", stall_id, 1'b0);
        check("ar_mrd", ex_mem_read, 1'b0);
        check("ar_op1", ex_op1, 32'h0);
        check("ar_pc", ex_pc, 32'h0);
        #2 rst_n = 1'b1;
        id_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ar_after_valid", ex_valid, 1'b0);
        check("ar_after_stall", stall_id, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
